// File: rtl/iter_divider_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
// Width defaults to 64 and is overridden per instance for 32-bit cores.
interface iter_divider_if #(
  parameter int WIDTH = 64
);
  logic             Start;
  logic             Flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             W64;
  logic [2:0]       Funct3;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  modport master (
    output Start, Flush, A, B, W64, Funct3,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Flush, A, B, W64, Funct3,
    output Busy, Done, Result
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for div/divu/rem/remu and the RV64 W-forms, one quotient bit per cycle.
// Optional leading-zero early termination is enabled by defining DIV_EARLY_TERM_EN.
module iter_divider #(
  parameter int WIDTH = 64,
  parameter int LOGW  = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  iter_divider_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [LOGW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             rem_sel_q, rem_sel_d;
  logic             w_q, w_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             signed_op, w_op, div_zero, last_iter;
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, a_aligned, q_init;
  logic [LOGW-1:0]  n_iter, lz, k_iter;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] r_next, q_next, q_fix, r_fix;
  logic             unused_funct3;

  assign unused_funct3 = bus.Funct3[2];

  function automatic logic [WIDTH-1:0] w_fix(input logic [WIDTH-1:0] v, input logic w);
    return w ? WIDTH'($signed(v[31:0])) : v;
  endfunction

`ifdef DIV_EARLY_TERM_EN
  // Zeros above the first set bit; capped so at least one iteration always runs.
  function automatic logic [LOGW-1:0] lead_zeros(input logic [WIDTH-1:0] x, input logic [LOGW-1:0] n);
    logic [LOGW-1:0] cnt;
    logic            found;
    cnt   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) found = 1'b1;
      else if (!found) cnt = cnt + 1'b1;
    end
    if (cnt >= n) cnt = n - 1'b1;
    return cnt;
  endfunction
`endif

  // Operand preparation, evaluated in the latch cycle.
  always_comb begin
    signed_op = ~bus.Funct3[0];
    w_op      = (WIDTH == 64) && bus.W64;
    if (w_op) begin
      a_ext = signed_op ? WIDTH'($signed(bus.A[31:0])) : WIDTH'(bus.A[31:0]);
      b_ext = signed_op ? WIDTH'($signed(bus.B[31:0])) : WIDTH'(bus.B[31:0]);
    end else begin
      a_ext = bus.A;
      b_ext = bus.B;
    end
    a_mag     = (signed_op && a_ext[WIDTH-1]) ? -a_ext : a_ext;
    b_mag     = (signed_op && b_ext[WIDTH-1]) ? -b_ext : b_ext;
    div_zero  = (b_ext == '0);
    n_iter    = w_op ? LOGW'(32) : LOGW'(WIDTH);
    // Park the N significant dividend bits at the top of Q so they shift into R first.
    a_aligned = a_mag << (LOGW'(WIDTH) - n_iter);
`ifdef DIV_EARLY_TERM_EN
    lz        = lead_zeros(a_aligned, n_iter);
`else
    lz        = '0;
`endif
    k_iter    = n_iter - lz;
    q_init    = a_aligned << lz;
  end

  // One restoring step; R never exceeds D-1, so WIDTH bits hold it between steps
  // while the shifted value and the trial difference carry the extra borrow bits.
  always_comb begin
    rem_shift = {r_q, q_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, d_q};
    borrow    = trial[WIDTH+1];
    r_next    = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next    = {q_q[WIDTH-2:0], ~borrow};
    q_fix     = neg_q_q ? -q_next : q_next;
    r_fix     = neg_r_q ? -r_next : r_next;
    last_iter = (cnt_q == LOGW'(1));
  end

  // FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.Start) state_d = div_zero ? S_DONE : S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.Flush) state_d = S_IDLE;
  end

  // FSM: outputs.
  always_comb begin
    bus.Busy = (state_q == S_BUSY);
    bus.Done = (state_q == S_DONE) && !bus.Flush;
  end

  assign bus.Result = result_q;

  // Datapath next values.
  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    rem_sel_d = rem_sel_q;
    w_d       = w_q;
    result_d  = result_q;
    if (!bus.Flush) begin
      unique case (state_q)
        S_IDLE: if (bus.Start) begin
          cnt_d     = k_iter;
          r_d       = '0;
          q_d       = q_init;
          d_d       = b_mag;
          neg_q_d   = signed_op & (a_ext[WIDTH-1] ^ b_ext[WIDTH-1]);
          neg_r_d   = signed_op & a_ext[WIDTH-1];
          rem_sel_d = bus.Funct3[1];
          w_d       = w_op;
          if (div_zero) result_d = w_fix(bus.Funct3[1] ? a_ext : '1, w_op);
        end
        S_BUSY: begin
          cnt_d = cnt_q - 1'b1;
          r_d   = r_next;
          q_d   = q_next;
          if (last_iter) result_d = w_fix(rem_sel_q ? r_fix : q_fix, w_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      w_q       <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      rem_sel_q <= rem_sel_d;
      w_q       <= w_d;
      result_q  <= result_d;
    end
  end

endmodule
